// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and flow controller for a classic five-stage pipeline. It produces
// the pipeline-register write enables and synchronous bubble inserts for:
//   - data-memory wait states (highest priority; holds the whole pipe),
//   - taken branches resolved in EX (flush IF/ID and ID/EX),
//   - load-use hazards (hold PC and IF/ID for one cycle, bubble into EX),
//   - interrupts (redirect PC to the vector, then flush the front end),
//   - jumps decoded in ID (flush IF/ID).
// All outputs are combinational from the state and the current inputs.
//
// Ports
//   clk               in   single clock, rising edge
//   reset             in   asynchronous active-low reset
//   IDEX_MemRead      in   instruction in EX is a load
//   IDEX_rt    [4:0]  in   destination register of that load
//   IFID_rs    [4:0]  in   source register rs of the instruction in ID
//   IFID_rt    [4:0]  in   source register rt of the instruction in ID
//   EX_branch_taken   in   branch resolved taken in EX
//   ID_jump           in   jump decoded in ID
//   mem_req           in   EX/MEM stage is accessing data memory
//   mem_ready         in   data memory completes this cycle
//   irq               in   level interrupt request
//   pc_we, ifid_we, idex_we, exmem_we                 out  register write enables
//   ifid_clear, idex_clear, exmem_clear, memwb_clear  out  bubble inserts
//   pc_sel_irq        out  PC loads the interrupt vector
//   irq_ack           out  one-cycle interrupt acknowledge
//   stall_cnt [15:0]  out  saturating count of cycles with pc_we=0
//
// Build option
//   PIPE_PERF_CNT_EN  when defined, adds the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_rt,
    input  logic [4:0] IFID_rs,
    input  logic [4:0] IFID_rt,
    input  logic       EX_branch_taken,
    input  logic       ID_jump,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       irq,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idex_we,
    output logic       exmem_we,
    output logic       ifid_clear,
    output logic       idex_clear,
    output logic       exmem_clear,
    output logic       memwb_clear,
    output logic       pc_sel_irq,
    output logic       irq_ack
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        IRQ_FLUSH = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   irq_pending_q, irq_pending_d;

    logic mem_stall;
    logic load_use;

    assign mem_stall = mem_req & ~mem_ready;

    // Register 0 is hardwired to zero, so a load targeting it never creates
    // a real dependency.
    assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default before the
        // case, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        irq_pending_d = irq_pending_q | irq;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        ifid_clear    = 1'b0;
        idex_clear    = 1'b0;
        exmem_clear   = 1'b0;
        memwb_clear   = 1'b0;
        pc_sel_irq    = 1'b0;
        irq_ack       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    // Freeze everything; the completing access must not write
                    // back twice, so MEM/WB takes a bubble.
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_we     = 1'b0;
                    exmem_we    = 1'b0;
                    memwb_clear = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (EX_branch_taken) begin
                    ifid_clear = 1'b1;
                    idex_clear = 1'b1;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_clear = 1'b1;
                end else if (irq_pending_q) begin
                    // Acceptance wins over a same-cycle irq: a still-high
                    // level request re-pends on the following cycle.
                    pc_sel_irq    = 1'b1;
                    irq_ack       = 1'b1;
                    irq_pending_d = 1'b0;
                    state_d       = IRQ_FLUSH;
                end else if (ID_jump) begin
                    ifid_clear = 1'b1;
                end
            end

            MEM_WAIT: begin
                // Release happens in the mem_ready cycle itself (zero
                // restart latency); everything but irq latching is ignored.
                if (!mem_ready) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_we     = 1'b0;
                    exmem_we    = 1'b0;
                    memwb_clear = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            IRQ_FLUSH: begin
                ifid_clear  = 1'b1;
                idex_clear  = 1'b1;
                exmem_clear = 1'b1;
                state_d     = RUN;
            end

            default: state_d = RUN;
        endcase

        // While reset is held the pipe is frozen and fully bubbled.
        if (!reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
            pc_sel_irq  = 1'b0;
            irq_ack     = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl: a table of single-cycle RUN cases,
// hand-written multi-cycle sequences (memory wait, interrupt during a wait,
// reset during a wait), then randomized stimulus against a behavioural model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_rt;
    logic [4:0] IFID_rs;
    logic [4:0] IFID_rt;
    logic       EX_branch_taken;
    logic       ID_jump;
    logic       mem_req;
    logic       mem_ready;
    logic       irq;
    logic       pc_we, ifid_we, idex_we, exmem_we;
    logic       ifid_clear, idex_clear, exmem_clear, memwb_clear;
    logic       pc_sel_irq, irq_ack;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipeline_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_rt         (IDEX_rt),
        .IFID_rs         (IFID_rs),
        .IFID_rt         (IFID_rt),
        .EX_branch_taken (EX_branch_taken),
        .ID_jump         (ID_jump),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .irq             (irq),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .ifid_clear      (ifid_clear),
        .idex_clear      (idex_clear),
        .exmem_clear     (exmem_clear),
        .memwb_clear     (memwb_clear),
        .pc_sel_irq      (pc_sel_irq),
        .irq_ack         (irq_ack)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order:
    // {pc_we, ifid_we, idex_we, exmem_we,
    //  ifid_clear, idex_clear, exmem_clear, memwb_clear, pc_sel_irq, irq_ack}
    logic [9:0] outs;
    assign outs = {pc_we, ifid_we, idex_we, exmem_we,
                   ifid_clear, idex_clear, exmem_clear, memwb_clear,
                   pc_sel_irq, irq_ack};

    localparam logic [9:0] O_RESET = 10'b0000_1111_00;
    localparam logic [9:0] O_RUN   = 10'b1111_0000_00;
    localparam logic [9:0] O_MEMST = 10'b0000_0001_00;
    localparam logic [9:0] O_BR    = 10'b1111_1100_00;
    localparam logic [9:0] O_LU    = 10'b0011_0100_00;
    localparam logic [9:0] O_JMP   = 10'b1111_1000_00;
    localparam logic [9:0] O_IRQ   = 10'b1111_0000_11;
    localparam logic [9:0] O_FLUSH = 10'b1111_1110_00;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_RUN = 0, M_WAIT = 1, M_FLUSH = 2;
    int m_mode = M_RUN;
    bit m_pend = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    int m_cnt  = 0;
`endif

    function automatic bit m_load_use();
        return IDEX_MemRead && (IDEX_rt != 5'd0) &&
               ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
    endfunction

    // Expected outputs from the priority list: memory wait, branch, load-use,
    // interrupt, jump, then the free-running default.
    function automatic logic [9:0] model_out();
        if (!reset) return O_RESET;
        if (m_mode == M_FLUSH) return O_FLUSH;
        if (m_mode == M_WAIT) return mem_ready ? O_RUN : O_MEMST;
        if (mem_req && !mem_ready) return O_MEMST;
        if (EX_branch_taken) return O_BR;
        if (m_load_use()) return O_LU;
        if (m_pend) return O_IRQ;
        if (ID_jump) return O_JMP;
        return O_RUN;
    endfunction

    function automatic void model_reset();
        m_mode = M_RUN;
        m_pend = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        m_cnt  = 0;
`endif
    endfunction

    function automatic void model_step();
        logic [9:0] o;
        bit accepted;
        if (!reset) begin
            model_reset();
            return;
        end
        o = model_out();
        accepted = o[0];
`ifdef PIPE_PERF_CNT_EN
        if (!o[9] && m_cnt < 65535) m_cnt++;
`endif
        case (m_mode)
            M_RUN:   if (mem_req && !mem_ready) m_mode = M_WAIT;
                     else if (accepted)        m_mode = M_FLUSH;
            M_WAIT:  if (mem_ready) m_mode = M_RUN;
            default: m_mode = M_RUN;
        endcase
        m_pend = accepted ? 1'b0 : (m_pend | irq);
    endfunction

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare against the model, then clock.
    task automatic cycle(input string name);
        @(negedge clk);
        check(name, {22'd0, outs}, {22'd0, model_out()});
`ifdef PIPE_PERF_CNT_EN
        check({name, "_cnt"}, {16'd0, stall_cnt}, m_cnt);
`endif
        advance();
    endtask

    // Compare against a hand-derived constant, then clock.
    task automatic cycle_exp(input string name, input logic [9:0] exp);
        @(negedge clk);
        check(name, {22'd0, outs}, {22'd0, exp});
        advance();
    endtask

    task automatic set_idle();
        IDEX_MemRead = 0; IDEX_rt = 0; IFID_rs = 0; IFID_rt = 0;
        EX_branch_taken = 0; ID_jump = 0; mem_req = 0; mem_ready = 0; irq = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        advance();
        reset = 1'b1;
    endtask

    // ---------------- single-cycle RUN vector table ----------------
    typedef struct {
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       jmp;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, O_RUN, "idle"};
        vecs[1]  = '{1'b1, 5'd5,  5'd5,  5'd3,  1'b0, 1'b0, O_LU,  "lu_rs"};
        vecs[2]  = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b0, 1'b0, O_LU,  "lu_rt"};
        vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, O_RUN, "lu_r0"};
        vecs[4]  = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0, O_RUN, "no_memread"};
        vecs[5]  = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 1'b0, O_RUN, "no_match"};
        vecs[6]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, O_BR,  "branch"};
        vecs[7]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, O_BR,  "branch_over_lu"};
        vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, O_JMP, "jump"};
        vecs[9]  = '{1'b1, 5'd31, 5'd31, 5'd2,  1'b0, 1'b1, O_LU,  "lu_over_jump"};
        vecs[10] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, O_BR,  "branch_over_jump"};
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        set_idle();
        model_reset();
        #1;

        // Reset state
        cycle_exp("reset_outs0", O_RESET);
        cycle_exp("reset_outs1", O_RESET);
        reset = 1'b1;
        cycle_exp("after_reset", O_RUN);

        // Table
        for (int i = 0; i < 11; i++) begin
            IDEX_MemRead    = vecs[i].memread;
            IDEX_rt         = vecs[i].ex_rt;
            IFID_rs         = vecs[i].rs;
            IFID_rt         = vecs[i].rt;
            EX_branch_taken = vecs[i].br;
            ID_jump         = vecs[i].jmp;
            cycle_exp(vecs[i].name, vecs[i].exp);
        end
        set_idle();

        // Memory wait: three stalled cycles, release in the mem_ready cycle.
        pulse_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle_exp("mem_wait", O_MEMST);
        mem_ready = 1'b1;
        cycle_exp("mem_release", O_RUN);
`ifdef PIPE_PERF_CNT_EN
        check("mem_wait_cnt", {16'd0, stall_cnt}, 32'd3);
`endif
        set_idle();
        cycle_exp("mem_after", O_RUN);

        // Interrupt pulsed during a wait is taken right after release.
        mem_req = 1'b1;
        cycle_exp("wirq_enter", O_MEMST);
        irq = 1'b1;
        cycle_exp("wirq_hold", O_MEMST);
        irq = 1'b0;
        cycle_exp("wirq_hold2", O_MEMST);
        mem_ready = 1'b1;
        cycle_exp("wirq_release", O_RUN);
        set_idle();
        cycle_exp("wirq_accept", O_IRQ);
        cycle_exp("wirq_flush", O_FLUSH);
        cycle_exp("wirq_after", O_RUN);

        // Reset in the middle of a wait with an interrupt pending.
        mem_req = 1'b1;
        cycle_exp("rst_enter", O_MEMST);
        irq = 1'b1;
        cycle_exp("rst_pend", O_MEMST);
        irq = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        cycle_exp("rst_mid_wait", O_RESET);
        set_idle();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_ack", {31'd0, irq_ack}, 32'd0);
            check("rst_run", {22'd0, outs}, {22'd0, O_RUN});
`ifdef PIPE_PERF_CNT_EN
            check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
            advance();
        end

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            bit new_reset;
            IDEX_MemRead    = 1'($urandom_range(0, 1));
            IDEX_rt         = 5'($urandom_range(0, 3));
            IFID_rs         = 5'($urandom_range(0, 3));
            IFID_rt         = 5'($urandom_range(0, 3));
            EX_branch_taken = ($urandom_range(0, 7) == 0);
            ID_jump         = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            irq             = ($urandom_range(0, 15) == 0);
            new_reset       = ($urandom_range(0, 199) != 0);
            if (!new_reset) model_reset();
            reset = new_reset;
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; state is forced while reset=0.
REQ-003 SHALL have inputs IDEX_MemRead, 1, and IDEX_rt, 5, which identify the load currently in EX.
REQ-004 SHALL have inputs IFID_rs and IFID_rt, 5 each, the source registers of the instruction in ID.
REQ-005 SHALL have inputs EX_branch_taken, 1 (branch resolved taken in EX), and ID_jump, 1 (jump decoded in ID).
REQ-006 SHALL have inputs mem_req, 1 (EX/MEM MemRead|MemWrite), and mem_ready, 1 (data memory completes this cycle).
REQ-007 SHALL have input irq, 1, a level interrupt request.
REQ-008 SHALL have outputs pc_we, ifid_we, idex_we and exmem_we, 1 each, the register write enables.
REQ-009 SHALL have outputs ifid_clear, idex_clear, exmem_clear and memwb_clear, 1 each, synchronous bubble inserts.
REQ-010 SHALL have outputs pc_sel_irq, 1 (PC loads the vector), and irq_ack, 1 (one-cycle acknowledge).
REQ-011 SHALL have output stall_cnt, 16, the stall-cycle count, present only when PIPE_PERF_CNT_EN is defined.

Function
REQ-012 SHALL implement a state machine with states RUN, MEM_WAIT and IRQ_FLUSH.
REQ-013 SHALL drive outputs combinationally from state and inputs; the default in RUN is all *_we=1 and all clears, pc_sel_irq and irq_ack =0.
REQ-014 SHALL, in RUN with mem_req=1 and mem_ready=0, drive all *_we=0 and memwb_clear=1, and move to MEM_WAIT; this condition has highest priority.
REQ-015 SHALL, in MEM_WAIT, hold all *_we=0 and memwb_clear=1 while mem_ready=0, and ignore branch, jump, load-use and irq.
REQ-016 SHALL, in MEM_WAIT with mem_ready=1, release to the RUN defaults in that same cycle and return to RUN; the latency from mem_ready to restart is 0 cycles.
REQ-017 SHALL, in RUN with EX_branch_taken=1, assert ifid_clear=1 and idex_clear=1 with pc_we=1; this ranks second in priority.
REQ-018 SHALL detect a load-use hazard as IDEX_MemRead=1, IDEX_rt!=0, and IDEX_rt equal to IFID_rs or IFID_rt.
REQ-019 SHALL, on a load-use hazard, drive pc_we=0, ifid_we=0 and idex_clear=1 for exactly one cycle; this ranks third.
REQ-020 SHALL, in RUN with ID_jump=1 and no higher-priority event, assert ifid_clear=1.
REQ-021 SHALL set an irq_pending flag on irq=1; the flag clears only on acceptance or reset.
REQ-022 SHALL accept an interrupt only in RUN when irq_pending=1 and none of REQ-014, REQ-017 or REQ-019 is active.
REQ-023 SHALL, on accepting an interrupt, assert pc_sel_irq=1, pc_we=1 and irq_ack=1, clear irq_pending, and move to IRQ_FLUSH.
REQ-024 SHALL, in IRQ_FLUSH, assert ifid_clear, idex_clear and exmem_clear for one cycle, then return to RUN.
REQ-025 SHALL handle an irq that arrives during MEM_WAIT by holding it pending and taking it in the first eligible RUN cycle.

Reset
REQ-026 SHALL, while reset=0, set state=RUN and irq_pending=0 (and stall_cnt=0 when present).
REQ-027 SHALL, while reset=0, drive all *_we=0, all clears=1, pc_sel_irq=0 and irq_ack=0.
REQ-028 SHALL, on a reset asserted in MEM_WAIT or IRQ_FLUSH, abandon the operation; no acknowledge is issued afterwards.

Configuration
REQ-029 SHALL, with PIPE_PERF_CNT_EN defined, increment stall_cnt every cycle in which pc_we=0 outside reset, saturating at 16'hFFFF.
REQ-030 SHALL, without PIPE_PERF_CNT_EN defined, omit the stall_cnt port and its counter; all other behaviour is identical.

Verification
REQ-031 SHALL cover load-use: IDEX_MemRead=1, IDEX_rt=5, IFID_rs=5 -> one cycle of pc_we=0, ifid_we=0, idex_clear=1; and IDEX_rt=0 -> no stall.
REQ-032 SHALL cover memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> *_we=0 for 3 cycles, then =1 in the mem_ready cycle; stall_cnt=3 when enabled.
REQ-033 SHALL cover priority: EX_branch_taken=1 with a load-use hazard in the same cycle -> ifid_clear=idex_clear=1 and pc_we=1, no stall.
REQ-034 SHALL cover an interrupt during a wait: irq pulsed in MEM_WAIT -> irq_ack=1 and pc_sel_irq=1 in the first RUN cycle after mem_ready, then one cycle of ifid/idex/exmem_clear=1.
REQ-035 SHALL cover reset mid-wait: reset=0 in MEM_WAIT with irq_pending=1 -> after release, state=RUN, irq_ack never asserts, stall_cnt=0.
